// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler
//   Round-robin scheduler that shares one UDP/IPv4/Ethernet transmit byte
//   stream between NUM_REQ payload sources. For each grant it builds the
//   42-byte Ethernet+IPv4+UDP header, fills in the IPv4 header checksum,
//   sends the header and then forwards exactly req_len payload bytes from
//   the granted source. The MAC adds preamble and FCS.
//
//   Build option: define UDP_TX_PAD_EN to pad frames shorter than 60 bytes
//   with 0x00 (IP/UDP lengths keep the unpadded values).
//
// Handshakes: a byte moves on m_* when m_valid_o && m_ready_i on a rising
//   clk_i edge; likewise on s_* with s_valid_i[i] && s_ready_o[i]. Neither
//   valid depends on its own ready. req_ack_o is a one-cycle grant; the
//   request fields of that source are captured on the same edge.
//
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   cfg_mac_*/cfg_ip_*   static addressing
//   req_*                per-source request, length and UDP ports
//   req_ack_o            grant pulse
//   s_data/valid/ready   per-source payload streams
//   m_data/valid/last/ready  byte stream to the MAC
//   busy_o               frame in progress
//   len_err_o            sticky: a request asked for more than 1472 bytes
module udp_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TTL     = 64,
  parameter int LEN_W   = 11
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [47:0]              cfg_mac_src_i,
  input  logic [47:0]              cfg_mac_dst_i,
  input  logic [31:0]              cfg_ip_src_i,
  input  logic [31:0]              cfg_ip_dst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ*16-1:0]    req_port_src_i,
  input  logic [NUM_REQ*16-1:0]    req_port_dst_i,
  output logic [NUM_REQ-1:0]       req_ack_o,
  input  logic [NUM_REQ*8-1:0]     s_data_i,
  input  logic [NUM_REQ-1:0]       s_valid_i,
  output logic [NUM_REQ-1:0]       s_ready_o,
  output logic [7:0]               m_data_o,
  output logic                     m_valid_o,
  output logic                     m_last_o,
  input  logic                     m_ready_i,
  output logic                     busy_o,
  output logic                     len_err_o
);
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_PAY = 1472;

`ifdef UDP_TX_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_CSUM, S_HDR, S_PAY, S_PAD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_CSUM, S_HDR, S_PAY} state_t;
`endif

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] gnt_idx;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      sport_q;
  logic [15:0]      dport_q;
  logic [15:0]      ident;
  logic [15:0]      cnt;
  logic [5:0]       hdr_idx;
  logic [7:0]       hdr [42];

  // Round-robin pick: first request above the last grant, wrapping.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] j;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IDX_W'((32'(rr) + 32'(k)) % 32'(NUM_REQ));
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  logic [LEN_W-1:0] len_sel;
  logic             len_big;
  logic [LEN_W-1:0] len_clamp;
  assign len_sel   = req_len_i[pick*LEN_W +: LEN_W];
  assign len_big   = 32'(len_sel) > 32'(MAX_PAY);
  assign len_clamp = len_big ? LEN_W'(MAX_PAY) : len_sel;

  logic [15:0] total_len;
  logic [15:0] udp_len;
  assign total_len = 16'd28 + 16'(len_q);
  assign udp_len   = 16'd8 + 16'(len_q);

  // IPv4 header checksum over bytes 14..33; the checksum field is still zero
  // here. Ten words cannot carry more than twice, so two folds are enough.
  logic [19:0] csum_acc;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] csum;
  always_comb begin
    csum_acc = '0;
    for (int i = 0; i < 10; i++)
      csum_acc = csum_acc + 20'({hdr[14+2*i], hdr[15+2*i]});
    fold1 = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
    csum  = ~fold2;
  end

  logic pay_last;
  assign pay_last = (32'(cnt) + 32'd1) == 32'(len_q);

`ifdef UDP_TX_PAD_EN
  logic need_pad;
  assign need_pad = 32'(len_q) < 32'd18;  // 42 + len < 60
`endif

  always_comb begin
    req_ack_o = '0;
    if (rstn_i && state == S_IDLE && found) req_ack_o[pick] = 1'b1;
  end

  assign busy_o = (state != S_IDLE);

  always_comb begin
    m_data_o  = 8'h00;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    s_ready_o = '0;
    case (state)
      S_HDR: begin
        m_data_o  = hdr[hdr_idx];
        m_valid_o = 1'b1;
`ifdef UDP_TX_PAD_EN
        m_last_o  = 1'b0;  // an empty payload always pads
`else
        m_last_o  = (hdr_idx == 6'd41) && (len_q == '0);
`endif
      end
      S_PAY: begin
        m_data_o           = s_data_i[gnt_idx*8 +: 8];
        m_valid_o          = s_valid_i[gnt_idx];
        s_ready_o[gnt_idx] = m_ready_i;
`ifdef UDP_TX_PAD_EN
        m_last_o           = pay_last && !need_pad;
`else
        m_last_o           = pay_last;
`endif
      end
`ifdef UDP_TX_PAD_EN
      S_PAD: begin
        m_valid_o = 1'b1;
        m_last_o  = (cnt == 16'd59);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      rr        <= IDX_W'(NUM_REQ - 1);
      gnt_idx   <= '0;
      len_q     <= '0;
      sport_q   <= '0;
      dport_q   <= '0;
      ident     <= '0;
      cnt       <= '0;
      hdr_idx   <= '0;
      len_err_o <= 1'b0;
      for (int i = 0; i < 42; i++) hdr[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt_idx <= pick;
            rr      <= pick;
            len_q   <= len_clamp;
            sport_q <= req_port_src_i[pick*16 +: 16];
            dport_q <= req_port_dst_i[pick*16 +: 16];
            if (len_big) len_err_o <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          for (int i = 0; i < 6; i++) begin
            hdr[i]   <= cfg_mac_dst_i[47-8*i -: 8];
            hdr[6+i] <= cfg_mac_src_i[47-8*i -: 8];
          end
          hdr[12] <= 8'h08;
          hdr[13] <= 8'h00;
          hdr[14] <= 8'h45;
          hdr[15] <= 8'h00;
          hdr[16] <= total_len[15:8];
          hdr[17] <= total_len[7:0];
          hdr[18] <= ident[15:8];
          hdr[19] <= ident[7:0];
          hdr[20] <= 8'h40;
          hdr[21] <= 8'h00;
          hdr[22] <= 8'(TTL);
          hdr[23] <= 8'h11;
          hdr[24] <= 8'h00;
          hdr[25] <= 8'h00;
          for (int i = 0; i < 4; i++) begin
            hdr[26+i] <= cfg_ip_src_i[31-8*i -: 8];
            hdr[30+i] <= cfg_ip_dst_i[31-8*i -: 8];
          end
          hdr[34] <= sport_q[15:8];
          hdr[35] <= sport_q[7:0];
          hdr[36] <= dport_q[15:8];
          hdr[37] <= dport_q[7:0];
          hdr[38] <= udp_len[15:8];
          hdr[39] <= udp_len[7:0];
          hdr[40] <= 8'h00;
          hdr[41] <= 8'h00;
          state   <= S_CSUM;
        end
        S_CSUM: begin
          hdr[24] <= csum[15:8];
          hdr[25] <= csum[7:0];
          hdr_idx <= '0;
          state   <= S_HDR;
        end
        S_HDR: begin
          if (m_ready_i) begin
            if (hdr_idx == 6'd41) begin
              hdr_idx <= '0;
              cnt     <= '0;
              if (len_q == '0) begin
`ifdef UDP_TX_PAD_EN
                cnt   <= 16'd42;
                state <= S_PAD;
`else
                ident <= ident + 16'd1;
                state <= S_IDLE;
`endif
              end else begin
                state <= S_PAY;
              end
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        S_PAY: begin
          if (s_valid_i[gnt_idx] && m_ready_i) begin
            if (pay_last) begin
`ifdef UDP_TX_PAD_EN
              if (need_pad) begin
                cnt   <= 16'd42 + 16'(len_q);  // bytes sent so far
                state <= S_PAD;
              end else begin
                ident <= ident + 16'd1;
                state <= S_IDLE;
              end
`else
              ident <= ident + 16'd1;
              state <= S_IDLE;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
`ifdef UDP_TX_PAD_EN
        S_PAD: begin
          if (m_ready_i) begin
            if (cnt == 16'd59) begin
              ident <= ident + 16'd1;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb_udp_tx_scheduler
//   Randomized bench for udp_tx_scheduler. Expected frames come from a
//   byte-level model of the frame format (header built field by field,
//   checksum computed with integer arithmetic) and a round-robin model of
//   the grant order. A monitor collects every transferred byte and grant.
module tb_udp_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 11;
  localparam int TTL     = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rstn;
  logic [47:0]              cfg_mac_src, cfg_mac_dst;
  logic [31:0]              cfg_ip_src, cfg_ip_dst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*16-1:0]    req_port_src, req_port_dst;
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ*8-1:0]     s_data;
  logic [NUM_REQ-1:0]       s_valid, s_ready;
  logic [7:0]               m_data;
  logic                     m_valid, m_last, m_ready, busy, len_err;

  udp_tx_scheduler #(.NUM_REQ(NUM_REQ), .TTL(TTL), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_mac_src_i(cfg_mac_src), .cfg_mac_dst_i(cfg_mac_dst),
    .cfg_ip_src_i(cfg_ip_src), .cfg_ip_dst_i(cfg_ip_dst),
    .req_valid_i(req_valid), .req_len_i(req_len),
    .req_port_src_i(req_port_src), .req_port_dst_i(req_port_dst),
    .req_ack_o(req_ack),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
    .busy_o(busy), .len_err_o(len_err)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         exp_ack_q[$];
  int         got_ack_q[$];
  int         exp_frames = 0;
  int         frames_done = 0;
  int         viol_sready = 0;
  int         viol_ack = 0;
  int         mon_gnt = -1;
  bit         stall = 1'b0;

  logic [7:0]  src_mem [NUM_REQ][2048];
  int          src_ptr [NUM_REQ];
  int          t_len   [NUM_REQ];
  logic [15:0] t_sport [NUM_REQ];
  logic [15:0] t_dport [NUM_REQ];
  int          tb_rr = NUM_REQ - 1;
  int          tb_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
    int p = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx = (tb_rr + k) % NUM_REQ;
      if (p < 0 && mask[idx]) p = idx;
    end
    return p;
  endfunction

  task automatic push_frame(input int src, input int id);
    logic [7:0]  fr[$];
    logic [15:0] w [10];
    int          s;
    int          len = (t_len[src] > 1472) ? 1472 : t_len[src];
    for (int i = 0; i < 6; i++) fr.push_back(8'(cfg_mac_dst >> (40 - 8*i)));
    for (int i = 0; i < 6; i++) fr.push_back(8'(cfg_mac_src >> (40 - 8*i)));
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    w[0] = 16'h4500;
    w[1] = 16'(28 + len);
    w[2] = 16'(id);
    w[3] = 16'h4000;
    w[4] = {8'(TTL), 8'h11};
    w[5] = 16'h0000;
    w[6] = cfg_ip_src[31:16];
    w[7] = cfg_ip_src[15:0];
    w[8] = cfg_ip_dst[31:16];
    w[9] = cfg_ip_dst[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(w[i]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    w[5] = ~16'(s);
    for (int i = 0; i < 10; i++) begin
      fr.push_back(w[i][15:8]);
      fr.push_back(w[i][7:0]);
    end
    fr.push_back(t_sport[src][15:8]);
    fr.push_back(t_sport[src][7:0]);
    fr.push_back(t_dport[src][15:8]);
    fr.push_back(t_dport[src][7:0]);
    fr.push_back(8'((8 + len) >> 8));
    fr.push_back(8'(8 + len));
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    for (int i = 0; i < len; i++) fr.push_back(src_mem[src][i]);
`ifdef UDP_TX_PAD_EN
    while (fr.size() < 60) fr.push_back(8'h00);
`endif
    foreach (fr[i]) begin
      exp_q.push_back(fr[i]);
      exp_last_q.push_back(i == fr.size() - 1);
    end
  endtask

  // ---------------- monitor and stream driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        if (m_last) frames_done++;
      end
      if ($countones(req_ack) > 1) viol_ack++;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ack[i]) begin
          got_ack_q.push_back(i);
          mon_gnt    = i;
          src_ptr[i] = 0;
        end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s_ready[i] && i != mon_gnt) viol_sready++;
        if (s_valid[i] && s_ready[i] && src_ptr[i] < 2047) src_ptr[i]++;
      end
      @(posedge clk);
      #1;
      m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        s_valid[i]       = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data[i*8 +: 8] = src_mem[i][src_ptr[i]];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_src(input int i);
    for (int k = 0; k < 2048; k++) src_mem[i][k] = 8'($urandom);
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_len[i*LEN_W +: LEN_W] = LEN_W'(t_len[i]);
      req_port_src[i*16 +: 16]  = t_sport[i];
      req_port_dst[i*16 +: 16]  = t_dport[i];
    end
  endtask

  // Raise the requests in mask and wait for n grants. With drop_each a
  // source withdraws after its grant; otherwise all stay up until the n-th.
  task automatic run_grants(input logic [NUM_REQ-1:0] mask, input int n, input bit drop_each);
    logic [NUM_REQ-1:0] m = mask;
    logic [NUM_REQ-1:0] acked;
    int acks = 0;
    int cyc  = 0;
    for (int k = 0; k < n; k++) begin
      int p = rr_pick(m);
      exp_ack_q.push_back(p);
      push_frame(p, tb_id);
      tb_id = (tb_id + 1) & 16'hFFFF;
      tb_rr = p;
      if (drop_each) m[p] = 1'b0;
      exp_frames++;
    end
    @(posedge clk);
    #1;
    drive_fields();
    req_valid = mask;
    while (acks < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (|req_ack) begin
        acks++;
        acked = req_ack;
        @(posedge clk);
        #1;
        if (drop_each) req_valid = req_valid & ~acked;
        if (acks == n) req_valid = '0;
      end
    end
    req_valid = '0;
    check("grant_count", acks, n);
  endtask

  task automatic wait_frames();
    int cyc = 0;
    while (frames_done < exp_frames && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_timeout", frames_done, exp_frames);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_last_q.delete();
    got_q.delete();
    got_last_q.delete();
    exp_ack_q.delete();
    got_ack_q.delete();
    exp_frames  = 0;
    frames_done = 0;
  endtask

  task automatic compare_all(input string tag);
    int n, bad_d, bad_l, bad_a;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad_d = 0;
    bad_l = 0;
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) bad_d++;
      if (got_last_q[i] !== exp_last_q[i]) bad_l++;
    end
    check({tag, "_byte_errs"}, bad_d, 0);
    check({tag, "_last_errs"}, bad_l, 0);
    check({tag, "_nacks"}, got_ack_q.size(), exp_ack_q.size());
    bad_a = 0;
    for (int i = 0; i < got_ack_q.size() && i < exp_ack_q.size(); i++)
      if (got_ack_q[i] != exp_ack_q[i]) bad_a++;
    check({tag, "_grant_errs"}, bad_a, 0);
    clear_sb();
  endtask

  function automatic logic [15:0] got_word(input int i);
    return {got_q[i], got_q[i+1]};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int exp_n;
    int waited;
    rstn         = 1'b0;
    m_ready      = 1'b1;
    s_valid      = '0;
    s_data       = '0;
    req_valid    = '1;  // grants must stay masked while in reset
    req_len      = '0;
    req_port_src = '0;
    req_port_dst = '0;
    cfg_mac_src  = {16'($urandom), $urandom};
    cfg_mac_dst  = {16'($urandom), $urandom};
    cfg_ip_src   = $urandom;
    cfg_ip_dst   = $urandom;
    for (int i = 0; i < NUM_REQ; i++) begin
      fill_src(i);
      src_ptr[i] = 0;
      t_len[i]   = 0;
      t_sport[i] = 16'h0;
      t_dport[i] = 16'h0;
    end

    repeat (3) @(negedge clk);
    check("rst_ack", req_ack, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_len_err", len_err, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rstn      = 1'b1;

    // Eight frames with every source requesting: fair rotation from source 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      t_len[i]   = $urandom_range(0, 20);
      t_sport[i] = 16'($urandom);
      t_dport[i] = 16'($urandom);
    end
    run_grants('1, 8, 1'b0);
    wait_frames();
    for (int k = 0; k < 8 && k < got_ack_q.size(); k++)
      check($sformatf("grant_order%0d", k), got_ack_q[k], k % NUM_REQ);
    compare_all("rr8");

    // Single small frame, field spot checks.
    t_len[0]   = 4;
    t_sport[0] = 16'h1234;
    t_dport[0] = 16'h5678;
    run_grants(4'b0001, 1, 1'b1);
    wait_frames();
`ifdef UDP_TX_PAD_EN
    exp_n = 60;
`else
    exp_n = 46;
`endif
    check("t1_size", got_q.size(), exp_n);
    if (got_q.size() >= 42) begin
      check("t1_ethertype", got_word(12), 16'h0800);
      check("t1_ver_ihl", got_q[14], 8'h45);
      check("t1_total_len", got_word(16), 16'h0020);
      check("t1_udp_len", got_word(38), 16'h000C);
      check("t1_ports", {got_word(34), got_word(36)}, 32'h12345678);
      s = 0;
      for (int i = 0; i < 10; i++) s += int'(got_word(14 + 2*i));
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      check("t1_ip_csum_sum", s, 16'hFFFF);
    end
    if (got_last_q.size() >= exp_n) check("t1_last_pos", got_last_q[exp_n-1], 1);
    compare_all("t1");

    // Empty payload.
    t_len[2] = 0;
    run_grants(4'b0100, 1, 1'b1);
    wait_frames();
    compare_all("len0");

    // Short payload (padded when the pad option is built in).
    t_len[1] = 10;
    run_grants(4'b0010, 1, 1'b1);
    wait_frames();
    if (got_q.size() >= 42) check("len10_total_len", got_word(16), 16'h0026);
    compare_all("len10");

    // Stalls on both sides of the payload path.
    stall    = 1'b1;
    t_len[3] = 100;
    run_grants(4'b1000, 1, 1'b1);
    wait_frames();
    compare_all("stall100");

    // Random mixes under stalls.
    for (int r = 0; r < 4; r++) begin
      logic [NUM_REQ-1:0] mask;
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        fill_src(i);
        t_len[i]   = $urandom_range(0, 200);
        t_sport[i] = 16'($urandom);
        t_dport[i] = 16'($urandom);
      end
      run_grants(mask, $countones(mask), 1'b1);
      wait_frames();
      compare_all($sformatf("rand%0d", r));
    end
    stall = 1'b0;
    check("len_err_before", len_err, 0);

    // Reset in the middle of a payload.
    t_len[2] = 100;
    run_grants(4'b0100, 1, 1'b1);
    waited = 0;
    while (got_q.size() < 60 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("midpay_reached", got_q.size() >= 60, 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_last", m_last, 0);
    repeat (2) @(negedge clk);
    clear_sb();
    tb_rr = NUM_REQ - 1;
    tb_id = 0;
    t_len[0] = 5;
    t_len[1] = 7;
    run_grants(4'b0011, 2, 1'b1);
    wait_frames();
    if (got_ack_q.size() > 0) check("post_rst_first_grant", got_ack_q[0], 0);
    if (got_q.size() >= 20) check("post_rst_ident", got_word(18), 16'h0000);
    compare_all("post_rst");

    // Oversized request: clamped to 1472 bytes and flagged.
    t_len[1] = 2000;
    run_grants(4'b0010, 1, 1'b1);
    wait_frames();
    check("big_size", got_q.size(), 1514);
    check("big_len_err", len_err, 1);
    compare_all("big");

    check("sready_nongranted", viol_sready, 0);
    check("ack_onehot", viol_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
